axis_capture_ctrl: RTL and testbench
====================================

// Module: axis_capture_ctrl
// PURPOSE
//  Sequencer for the circular AXI-stream capture buffer (depth MEMORY_DEPTH, 1-cycle read latency,
//  read addr relative to write pointer, reads return 0 until buffer has wrapped). Arms and clears
//  the buffer, gates the always-ready source stream into it, and handles pre/post trigger capture.
//  After capture it drains the frozen buffer oldest-first as an AXI-stream frame with backpressure.
// PARAMETERS
//  MEMORY_DEPTH  32  entries in capture buffer; power of two, >=4
//  DATA_WIDTH    32  sample width
//  POST_SAMPLES  16  samples written after trigger; 1..MEMORY_DEPTH
// PORTS
//  clk            in   1     clock
//  rst            in   1     reset, synchronous, active-high
//  arm            in   1     pulse: start capture (honoured in IDLE only)
//  trigger        in   1     capture trigger (honoured in FILL once trig_ready)
//  busy           out  1     high in any state but IDLE
//  trig_ready     out  1     FILL and pre-count >= MEMORY_DEPTH-POST_SAMPLES
//  done           out  1     1-cycle pulse after last readout beat accepted
//  s_axis_tvalid  in   1     source sample valid
//  s_axis_tready  out  1     constant 1; samples outside FILL/POST are discarded
//  s_axis_tdata   in   DW    source sample
//  buf_tvalid     out  1     buffer write enable = s_axis_tvalid & (FILL|POST)
//  buf_tdata      out  DW    = s_axis_tdata
//  buf_tlast      out  1     buffer clear pulse (CLEAR state only)
//  buf_addr       out  AW    buffer read addr, AW=log2(MEMORY_DEPTH); 0 = oldest entry
//  buf_dout       in   DW    buffer read data, valid 1 cycle after buf_addr
//  m_axis_tvalid  out  1     readout beat valid
//  m_axis_tready  in   1     readout backpressure
//  m_axis_tdata   out  DW    readout sample (registered)
//  m_axis_tlast   out  1     high on beat MEMORY_DEPTH-1
// BEHAVIOUR
//  Reset: state IDLE; busy, trig_ready, done, buf_tvalid, buf_tlast, m_axis_tvalid, m_axis_tlast = 0;
//   buf_addr, m_axis_tdata = 0; all counters 0. Reset mid-operation aborts immediately to IDLE,
//   no done pulse, no tlast emitted.
//  FSM: IDLE -arm-> CLEAR (1 cycle, buf_tlast=1, buf_tvalid=0) -> FILL -trigger&trig_ready-> POST
//   -POST_SAMPLES-th write-> DRAIN -last beat accepted-> IDLE (done=1 that next cycle).
//  FILL: pre counter increments per accepted sample, saturates at MEMORY_DEPTH. Sample in the
//   trigger cycle is written and counts as pre-trigger. trigger while !trig_ready ignored.
//  POST: post counter counts writes; cycle writing the POST_SAMPLES-th sample is the last write,
//   next cycle is DRAIN. Total writes >= MEMORY_DEPTH guaranteed, so buffer has wrapped and
//   addr 0 maps to the oldest sample; trigger sample sits at addr MEMORY_DEPTH-POST_SAMPLES-1.
//  DRAIN: buf_tvalid=0 (write pointer frozen). buf_addr sweeps 0..MEMORY_DEPTH-1; address advances
//   only when the 2-entry output skid has room for the data returning next cycle. First
//   m_axis_tvalid no later than 2 cycles after DRAIN entry; with m_axis_tready held 1,
//   one beat/cycle, no bubbles. tvalid/tdata/tlast held stable while tvalid & !tready.
//   Exactly MEMORY_DEPTH beats per frame, tlast on final one only.
//  arm outside IDLE ignored; trigger outside FILL ignored; arm and trigger together in IDLE: arm only.
//  s_axis_tvalid during CLEAR/DRAIN/IDLE: dropped, buffer untouched.
//  Counters sized log2(MEMORY_DEPTH)+1; no wrap in pre/post counters.
// CONFIGURATION
//  `CAPTURE_CTRL_ABORT_EN defined: adds input abort (1 bit); abort in CLEAR/FILL/POST/DRAIN returns
//   to IDLE next cycle, drops any pending readout beat (m_axis_tvalid=0 without tlast), asserts
//   done for 1 cycle; abort in IDLE ignored; abort with arm in IDLE: arm wins.
//  Undefined: no abort port; capture completes only via DRAIN or rst.
// TESTING
//  arm, stream 0,1,2.. every cycle, trigger at sample 40 (defaults) -> frame 25..56, trigger
//   sample 40 at beat 15, tlast on beat 31, done 1 cycle after.
//  trigger asserted after only 5 samples in FILL -> ignored, trig_ready=0; later trigger accepted.
//  m_axis_tready toggling 1/0 every cycle during DRAIN -> 32 beats, data in order, no dup/loss.
//  s_axis_tvalid 50% duty during POST -> exactly 16 writes after trigger before DRAIN.
//  rst asserted mid-DRAIN (beat 10) -> next cycle IDLE, all outputs at reset values, no done.
//  ABORT_EN: abort in POST -> IDLE next cycle, done pulse, no m_axis beat; re-arm captures cleanly.

Source files
------------

// File: rtl/axis_capture_ctrl.sv
// Capture sequencer for a circular AXI-stream buffer: arm/clear, pre/post-trigger fill, framed drain.
// Optional abort input is enabled by defining CAPTURE_CTRL_ABORT_EN.
module axis_capture_ctrl #(
   parameter int MEMORY_DEPTH = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int POST_SAMPLES = 16,
   localparam int AW = $clog2(MEMORY_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  arm,
   input  logic                  trigger,
   output logic                  busy,
   output logic                  trig_ready,
   output logic                  done,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   output logic                  buf_tvalid,
   output logic [DATA_WIDTH-1:0] buf_tdata,
   output logic                  buf_tlast,
   output logic [AW-1:0]         buf_addr,
   input  logic [DATA_WIDTH-1:0] buf_dout,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast
`ifdef CAPTURE_CTRL_ABORT_EN
   ,
   input  logic                  abort
`endif
);

   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C   = CW'(MEMORY_DEPTH);
   localparam logic [CW-1:0] LAST_C    = CW'(MEMORY_DEPTH - 1);
   localparam logic [CW-1:0] POST_C    = CW'(POST_SAMPLES - 1);
   localparam logic [CW-1:0] PRE_MIN_C = CW'(MEMORY_DEPTH - POST_SAMPLES);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_FILL,
      ST_POST,
      ST_DRAIN
   } state_t;

   state_t                state;
   logic [CW-1:0]         pre_cnt;
   logic [CW-1:0]         post_cnt;
   logic [CW-1:0]         rd_cnt;
   logic                  pend_vld;
   logic                  pend_last;
   logic                  spare_vld;
   logic                  spare_last;
   logic [DATA_WIDTH-1:0] spare_data;
   logic                  pop;
   logic                  issue;
   logic [2:0]            fill_lvl;
   logic                  abort_hit;

`ifdef CAPTURE_CTRL_ABORT_EN
   assign abort_hit = abort && (state != ST_IDLE);
`else
   assign abort_hit = 1'b0;
`endif

   assign s_axis_tready = 1'b1;
   assign buf_tdata     = s_axis_tdata;
   assign buf_tvalid    = s_axis_tvalid && ((state == ST_FILL) || (state == ST_POST));
   assign buf_tlast     = (state == ST_CLEAR);
   assign busy          = (state != ST_IDLE);
   assign trig_ready    = (state == ST_FILL) && (pre_cnt >= PRE_MIN_C);

   // Entries the skid will hold once the in-flight read lands; a new read may
   // only be issued if that leaves a free slot for it.
   assign pop      = m_axis_tvalid && m_axis_tready;
   assign fill_lvl = 3'(m_axis_tvalid) + 3'(spare_vld) + 3'(pend_vld) - 3'(pop);
   assign issue    = (state == ST_DRAIN) && (rd_cnt < DEPTH_C) && (fill_lvl <= 3'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         done          <= 1'b0;
         pre_cnt       <= '0;
         post_cnt      <= '0;
         rd_cnt        <= '0;
         buf_addr      <= '0;
         pend_vld      <= 1'b0;
         pend_last     <= 1'b0;
         spare_vld     <= 1'b0;
         spare_last    <= 1'b0;
         spare_data    <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort_hit) begin
            state         <= ST_IDLE;
            done          <= 1'b1;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            spare_vld     <= 1'b0;
            pend_vld      <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (arm) begin
                     state <= ST_CLEAR;
                  end
               end
               ST_CLEAR: begin
                  pre_cnt       <= '0;
                  post_cnt      <= '0;
                  rd_cnt        <= '0;
                  buf_addr      <= '0;
                  pend_vld      <= 1'b0;
                  spare_vld     <= 1'b0;
                  m_axis_tvalid <= 1'b0;
                  m_axis_tlast  <= 1'b0;
                  state         <= ST_FILL;
               end
               ST_FILL: begin
                  if (s_axis_tvalid && (pre_cnt < DEPTH_C)) begin
                     pre_cnt <= pre_cnt + 1'b1;
                  end
                  if (trigger && trig_ready) begin
                     state <= ST_POST;
                  end
               end
               ST_POST: begin
                  if (s_axis_tvalid) begin
                     post_cnt <= post_cnt + 1'b1;
                     if (post_cnt == POST_C) begin
                        state <= ST_DRAIN;
                     end
                  end
               end
               ST_DRAIN: begin
                  pend_vld  <= issue;
                  pend_last <= issue && (rd_cnt == LAST_C);
                  if (issue) begin
                     rd_cnt   <= rd_cnt + 1'b1;
                     buf_addr <= buf_addr + 1'b1;
                  end
                  // Output register refills from the spare first so order is kept.
                  if (!m_axis_tvalid || pop) begin
                     if (spare_vld) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= spare_data;
                        m_axis_tlast  <= spare_last;
                        spare_vld     <= pend_vld;
                        spare_data    <= buf_dout;
                        spare_last    <= pend_last;
                     end else if (pend_vld) begin
                        m_axis_tvalid <= 1'b1;
                        m_axis_tdata  <= buf_dout;
                        m_axis_tlast  <= pend_last;
                     end else begin
                        m_axis_tvalid <= 1'b0;
                        m_axis_tlast  <= 1'b0;
                     end
                  end else if (pend_vld) begin
                     spare_vld  <= 1'b1;
                     spare_data <= buf_dout;
                     spare_last <= pend_last;
                  end
                  if (pop && m_axis_tlast) begin
                     state <= ST_IDLE;
                     done  <= 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_axis_capture_ctrl.sv
// Randomised bench for axis_capture_ctrl with a circular buffer model and a queue-based capture model.
module tb_axis_capture_ctrl;

   localparam int MD = 32;
   localparam int DW = 32;
   localparam int PS = 16;
   localparam int AW = $clog2(MD);

   localparam int P_IDLE  = 0;
   localparam int P_CLEAR = 1;
   localparam int P_FILL  = 2;
   localparam int P_POST  = 3;
   localparam int P_DRAIN = 4;

`ifdef CAPTURE_CTRL_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          arm = 1'b0;
   logic          trigger = 1'b0;
   logic          abort = 1'b0;
   logic          busy;
   logic          trig_ready;
   logic          done;
   logic          s_tvalid = 1'b0;
   logic          s_axis_tready;
   logic [DW-1:0] s_tdata = '0;
   logic          buf_tvalid;
   logic [DW-1:0] buf_tdata;
   logic          buf_tlast;
   logic [AW-1:0] buf_addr;
   logic [DW-1:0] buf_dout = '0;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b1;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tlast;

   int n_err = 0;
   int n_chk = 0;

   always #5 clk = ~clk;

   axis_capture_ctrl #(.MEMORY_DEPTH(MD), .DATA_WIDTH(DW), .POST_SAMPLES(PS)) dut (
      .clk(clk), .rst(rst), .arm(arm), .trigger(trigger),
      .busy(busy), .trig_ready(trig_ready), .done(done),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_tdata),
      .buf_tvalid(buf_tvalid), .buf_tdata(buf_tdata), .buf_tlast(buf_tlast),
      .buf_addr(buf_addr), .buf_dout(buf_dout),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast)
`ifdef CAPTURE_CTRL_ABORT_EN
      , .abort(abort)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Circular capture buffer: reads are relative to the write pointer, zero until wrapped.
   logic [DW-1:0] mem [MD];
   logic [AW-1:0] wp = '0;
   logic [AW-1:0] ra;
   bit            wrapped = 1'b0;
   assign ra = wp + buf_addr;

   always @(posedge clk) begin
      buf_dout <= wrapped ? mem[ra] : '0;
      if (buf_tlast) begin
         for (int i = 0; i < MD; i++) mem[i] <= '0;
         wp      <= '0;
         wrapped <= 1'b0;
      end else if (buf_tvalid) begin
         mem[wp] <= buf_tdata;
         wp      <= wp + 1'b1;
         if (wp == AW'(MD - 1)) wrapped <= 1'b1;
      end
   end

   // Reference model: phase, written-sample history, expected frame.
   int            ph = P_IDLE;
   int            pre_n = 0;
   int            post_n = 0;
   int            beat = 0;
   int            drain_cyc = 0;
   bit            done_exp = 1'b0;
   bit            hold_prev = 1'b0;
   bit            ready_all = 1'b0;
   logic [DW-1:0] hold_data = '0;
   logic          hold_last = 1'b0;
   logic [DW-1:0] wr_q [$];
   logic [DW-1:0] got [$];
   logic [DW-1:0] frame [MD];

   always @(negedge clk) begin : cmp
      bit trig_ok;
      check("busy", busy, ph != P_IDLE);
      check("trig_ready", trig_ready, (ph == P_FILL) && (pre_n >= MD - PS));
      check("buf_tlast", buf_tlast, ph == P_CLEAR);
      check("buf_tvalid", buf_tvalid, s_tvalid && (ph == P_FILL || ph == P_POST));
      check("s_tready", s_axis_tready, 1);
      check("done", done, done_exp);
      if (ph != P_DRAIN) begin
         check("m_tvalid_quiet", m_axis_tvalid, 0);
      end else begin
         if (hold_prev) begin
            check("hold_valid", m_axis_tvalid, 1);
            check("hold_data", m_axis_tdata, hold_data);
            check("hold_last", m_axis_tlast, hold_last);
         end
         if (drain_cyc == 2 && beat == 0) check("first_latency", m_axis_tvalid, 1);
         if (ready_all && drain_cyc >= 2 && beat < MD) check("no_bubble", m_axis_tvalid, 1);
         if (m_axis_tvalid && m_axis_tready) begin
            if (beat < MD) begin
               check("beat_data", m_axis_tdata, frame[beat]);
               check("beat_last", m_axis_tlast, beat == MD - 1);
            end else begin
               check("extra_beat", beat, MD - 1);
            end
            got.push_back(m_axis_tdata);
            beat++;
         end
         ready_all = ready_all && m_axis_tready;
      end
      hold_prev = (ph == P_DRAIN) && m_axis_tvalid && !m_axis_tready;
      hold_data = m_axis_tdata;
      hold_last = m_axis_tlast;

      if (rst) begin
         ph = P_IDLE;
         done_exp = 1'b0;
         hold_prev = 1'b0;
      end else begin
         done_exp = 1'b0;
         if (ABORT_EN && abort && ph != P_IDLE) begin
            ph = P_IDLE;
            done_exp = 1'b1;
            hold_prev = 1'b0;
         end else begin
            case (ph)
               P_IDLE: if (arm) ph = P_CLEAR;
               P_CLEAR: begin
                  ph = P_FILL;
                  wr_q.delete();
                  pre_n = 0;
                  post_n = 0;
               end
               P_FILL: begin
                  trig_ok = trigger && (pre_n >= MD - PS);
                  if (s_tvalid) begin
                     wr_q.push_back(s_tdata);
                     if (pre_n < MD) pre_n++;
                  end
                  if (trig_ok) ph = P_POST;
               end
               P_POST: begin
                  if (s_tvalid) begin
                     wr_q.push_back(s_tdata);
                     post_n++;
                     if (post_n == PS) begin
                        ph = P_DRAIN;
                        for (int k = 0; k < MD; k++) frame[k] = wr_q[wr_q.size() - MD + k];
                        beat = 0;
                        drain_cyc = 0;
                        ready_all = 1'b1;
                        got.delete();
                     end
                  end
               end
               P_DRAIN: begin
                  drain_cyc++;
                  if (beat >= MD) begin
                     ph = P_IDLE;
                     done_exp = 1'b1;
                  end
               end
               default: ph = P_IDLE;
            endcase
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   // vmode: 0 continuous, 1 continuous then 50% after trigger, 2 random 70%.
   // rmode: 0 ready held, 1 ready toggling, 2 ready random (plus stray arm pulses while busy).
   task automatic capture(input int base, input int trig_a, input int trig_b, input int vmode,
                          input int rmode, input int rst_beat, input int abort_cyc);
      int  src = 0;
      int  tcyc = 0;
      bit  trig_seen = 1'b0;
      bit  tog = 1'b0;
      bit  v;
      bit  finished = 1'b0;
      arm = 1'b1;
      trigger = 1'b1;
      cyc();
      arm = 1'b0;
      trigger = 1'b0;
      cyc();
      for (int c = 0; c < 600 && !finished; c++) begin
         abort = 1'b0;
         if (vmode == 0) v = 1'b1;
         else if (vmode == 1) v = trig_seen ? tog : 1'b1;
         else v = ($urandom_range(9) < 7);
         tog = ~tog;
         s_tvalid = v;
         s_tdata = DW'(base + src);
         trigger = v && (src == trig_a || src == trig_b);
         if (v && src == trig_b) trig_seen = 1'b1;
         if (rmode == 0) m_axis_tready = 1'b1;
         else if (rmode == 1) m_axis_tready = c[0];
         else m_axis_tready = $urandom_range(1) == 1;
         arm = (rmode == 2) && busy && ($urandom_range(15) == 0);
         if (abort_cyc >= 0 && trig_seen && tcyc == abort_cyc) abort = 1'b1;
         if (rst_beat >= 0 && ph == P_DRAIN && beat == rst_beat) rst = 1'b1;
         if (trig_seen) tcyc++;
         cyc();
         if (v) src++;
         if (rst) begin
            check("rst_buf_addr", buf_addr, 0);
            check("rst_tdata", m_axis_tdata, 0);
            check("rst_tlast", m_axis_tlast, 0);
            check("rst_tvalid", m_axis_tvalid, 0);
            check("rst_done", done, 0);
            rst = 1'b0;
            finished = 1'b1;
         end else if (done) begin
            finished = 1'b1;
         end
      end
      if (!finished) check("capture_timeout", 0, 1);
      abort = 1'b0;
      arm = 1'b0;
      trigger = 1'b0;
      s_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      cyc();
      $display("capture base=%0d trig=%0d vmode=%0d rmode=%0d beats=%0d", base, trig_b, vmode, rmode, got.size());
   endtask

   initial begin : stim
      repeat (3) cyc();
      rst = 1'b0;
      check("reset_buf_addr", buf_addr, 0);
      check("reset_tdata", m_axis_tdata, 0);
      check("reset_tvalid", m_axis_tvalid, 0);
      check("reset_tlast", m_axis_tlast, 0);
      check("reset_busy", busy, 0);
      cyc();

      capture(0, -1, 40, 0, 0, -1, -1);
      check("t1_beats", got.size(), 32);
      if (got.size() == 32) begin
         check("t1_first", got[0], 25);
         check("t1_trig_beat", got[15], 40);
         check("t1_last", got[31], 56);
      end

      capture(0, 5, 30, 0, 1, -1, -1);
      check("t2_beats", got.size(), 32);
      if (got.size() == 32) check("t2_trig_beat", got[15], 30);

      capture(1000, -1, 25, 1, 0, -1, -1);
      check("t3_beats", got.size(), 32);

      capture(2000, -1, 20, 0, 0, 10, -1);
      repeat (3) cyc();

`ifdef CAPTURE_CTRL_ABORT_EN
      capture(3000, -1, 24, 0, 0, -1, 5);
      check("abort_no_beats", got.size(), 0);
      capture(4000, -1, 24, 0, 0, -1, -1);
      check("rearm_beats", got.size(), 32);
`endif

      for (int r = 0; r < 6; r++) begin
         capture(10000 * (r + 1), $urandom_range(10), $urandom_range(60, 20),
                 $urandom_range(2), $urandom_range(2), -1, -1);
         check("rand_beats", got.size(), 32);
      end

      repeat (3) cyc();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
